div_sched: RTL

//  Shares one sequential shift-subtract divider datapath among NREQ requesters.
//  It arbitrates the requests, latches the winner's operands, and sequences the datapath through load and N step cycles.
//  It then returns quotient/remainder to the winner with a one-cycle done pulse.

---
 rtl/div_sched.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/div_sched.sv
// div_sched: arbitrates NREQ requesters onto one shared sequential shift-subtract divider datapath.
// Define DIV_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module div_sched #(
  parameter int N    = 8,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] dividend_in,
  input  logic [NREQ*N-1:0] divisor_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [N-1:0]      quotient,
  output logic [N-1:0]      remainder,
  output logic              dz,
  output logic              busy,
  output logic              dp_ld,
  output logic              dp_step,
  output logic [N-1:0]      dp_dividend,
  output logic [N-1:0]      dp_divisor,
  input  logic [N-1:0]      dp_quotient,
  input  logic [N-1:0]      dp_remainder
);

  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_owner;
  logic [N-1:0]  r_dividend, r_divisor, r_quotient, r_remainder;
  logic          r_zero, r_dz;

  logic          w_found, w_grant, w_sel_zero;
  logic [IW-1:0] w_win;
  logic [N-1:0]  w_sel_dividend, w_sel_divisor;
  int            w_idx;

`ifndef DIV_SCHED_FIXED_PRIO_EN
  logic [IW-1:0] r_ptr;
`endif

  // Winner search: first asserted request scanning upward from the search start.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned (no latch).
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef DIV_SCHED_FIXED_PRIO_EN
      w_idx = k;
`else
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
`endif
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = IW'(w_idx);
      end
    end
  end

  assign w_grant        = (r_state == S_IDLE) && w_found && !rst;
  assign w_sel_dividend = dividend_in[w_win*N +: N];
  assign w_sel_divisor  = divisor_in[w_win*N +: N];
  assign w_sel_zero     = (w_sel_divisor == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_grant) w_next = w_sel_zero ? S_DONE : S_LOAD;
      S_LOAD: w_next = S_RUN;
      S_RUN:  if (r_cnt == CW'(N - 1)) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Results are presented combinationally during DONE and held in registers afterwards.
  always_comb begin
    gnt       = '0;
    done      = '0;
    busy      = (r_state != S_IDLE);
    dp_ld     = (r_state == S_LOAD);
    dp_step   = (r_state == S_RUN);
    quotient  = r_quotient;
    remainder = r_remainder;
    dz        = r_dz;
    if (w_grant) gnt[w_win] = 1'b1;
    if (r_state == S_DONE) begin
      done[r_owner] = 1'b1;
      quotient      = r_zero ? '1 : dp_quotient;
      remainder     = r_zero ? r_dividend : dp_remainder;
      dz            = r_zero;
    end
  end

  assign dp_dividend = r_dividend;
  assign dp_divisor  = r_divisor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_owner     <= '0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_zero      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dz        <= 1'b0;
`ifndef DIV_SCHED_FIXED_PRIO_EN
      r_ptr       <= '0;
`endif
    end else begin
      if (w_grant) begin
        r_owner    <= w_win;
        r_dividend <= w_sel_dividend;
        r_divisor  <= w_sel_divisor;
        r_zero     <= w_sel_zero;
`ifndef DIV_SCHED_FIXED_PRIO_EN
        r_ptr      <= (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
`endif
      end
      case (r_state)
        S_LOAD:  r_cnt <= '0;
        S_RUN:   r_cnt <= (r_cnt == CW'(N - 1)) ? '0 : r_cnt + 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (r_state == S_DONE) begin
        r_quotient  <= quotient;
        r_remainder <= remainder;
        r_dz        <= r_zero;
      end
    end
  end

endmodule
